// File: rtl/pwm_bank.sv
// pwm_bank: bank of NCHAN double-buffered PWM channels sharing one
// prescaler and one WIDTH-bit period counter.
// Thresholds are written into a per-channel shadow register and copied to
// the active register only at the period wrap, so a channel never emits a
// torn period.
// Optional feature macro: PWM_BITREV_EN -- when defined, the compare value
// is the bit-reversed counter, which spreads the high ticks across the
// period instead of producing one contiguous pulse.
module pwm_bank #(
    parameter int NCHAN    = 2,
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [2:0]       i_wsel,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [NCHAN-1:0] o_pwm,
    output logic [NCHAN-1:0] o_pend,
    output logic             o_wrap
);

    logic             w_tick;
    logic             w_wrap_tick;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_cmp;
    logic             r_wrap;

    // Prescaler: with PRESCALE=1 every clock is a tick and no counter exists.
    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign w_tick = 1'b1;
        end else begin : g_pre
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] r_pre;

            // Count 0..PRESCALE-1; the tick is the cycle holding the last value.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_pre <= '0;
                end else if (r_pre == PRE_LAST) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end

            assign w_tick = (r_pre == PRE_LAST);
        end
    endgenerate

    assign w_cnt_inc   = r_cnt + WIDTH'(1);
    assign w_wrap_tick = w_tick && (r_cnt == {WIDTH{1'b1}});

    // The compare uses the post-increment count, so the value registered on
    // the wrap tick already belongs to tick 0 of the new period.
`ifdef PWM_BITREV_EN
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign w_cmp[gi] = w_cnt_inc[WIDTH-1-gi];
        end
    endgenerate
`else
    assign w_cmp = w_cnt_inc;
`endif

    // Period counter advances once per tick and wraps naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // WRAP pulse lands on the same edge that loads the active thresholds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_tick;
        end
    end

    assign o_wrap = r_wrap;

    // Per-channel shadow/active registers and output flop.
    genvar gc;
    generate
        for (gc = 0; gc < NCHAN; gc++) begin : g_chan
            logic [WIDTH-1:0] r_shadow;
            logic [WIDTH-1:0] r_active;
            logic [WIDTH-1:0] w_active_next;
            logic             r_pend;
            logic             r_pwm;
            logic             w_we;

            // Selects >= NCHAN match no channel, so such writes fall away.
            assign w_we          = i_wr && (i_wsel == 3'(gc));
            assign w_active_next = (w_wrap_tick && r_pend) ? r_shadow : r_active;

            // Shadow capture and pending flag; a write on the wrap tick keeps
            // PEND set so its value is applied at the following wrap.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_shadow <= '0;
                    r_pend   <= 1'b0;
                end else if (w_we) begin
                    r_shadow <= i_wdata;
                    r_pend   <= 1'b1;
                end else if (w_wrap_tick) begin
                    r_pend   <= 1'b0;
                end
            end

            // Active threshold and PWM output; both update only on ticks.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_active <= '0;
                    r_pwm    <= 1'b0;
                end else if (w_tick) begin
                    r_active <= w_active_next;
                    r_pwm    <= (w_cmp < w_active_next);
                end
            end

            assign o_pend[gc] = r_pend;
            assign o_pwm[gc]  = r_pwm;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed checks of pwm_bank. DUT a uses the default
// parameters (2 channels, 6 bits, PRESCALE=1); DUT b uses PRESCALE=4.
module tb_pwm_bank;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wr_a, wrap_a;
    logic [2:0] wsel_a;
    logic [5:0] wdata_a;
    logic [1:0] pwm_a, pend_a;

    logic       rst_b, wr_b, wrap_b;
    logic [2:0] wsel_b;
    logic [5:0] wdata_b;
    logic [1:0] pwm_b, pend_b;

    pwm_bank #(.NCHAN(2), .WIDTH(6), .PRESCALE(1)) u_a (
        .i_clk(clk), .i_rst(rst_a), .i_wr(wr_a), .i_wsel(wsel_a),
        .i_wdata(wdata_a), .o_pwm(pwm_a), .o_pend(pend_a), .o_wrap(wrap_a)
    );

    pwm_bank #(.NCHAN(2), .WIDTH(6), .PRESCALE(4)) u_b (
        .i_clk(clk), .i_rst(rst_b), .i_wr(wr_b), .i_wsel(wsel_b),
        .i_wdata(wdata_b), .o_pwm(pwm_b), .o_pend(pend_b), .o_wrap(wrap_b)
    );

    int checks = 0;
    int errors = 0;
    int hi0, hi1, pat0_err, pat1_err, wrap_err;
    int n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected PWM level at tick t of a period for threshold thr.
    function automatic logic exp_on(input int t, input int thr);
        logic [5:0] c;
        logic [5:0] r;
        c = t[5:0];
`ifdef PWM_BITREV_EN
        for (int k = 0; k < 6; k++) r[k] = c[5-k];
`else
        r = c;
`endif
        return (int'(r) < thr);
    endfunction

    // Count negedges until WRAP on DUT a, bounded.
    task automatic wait_wrap_a(output int cnt);
        cnt = 0;
        while (wrap_a !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Starting on a WRAP negedge, sample one full period of DUT a and end
    // on the next WRAP negedge.
    task automatic measure(input int thr0, input int thr1);
        hi0 = 0; hi1 = 0; pat0_err = 0; pat1_err = 0; wrap_err = 0;
        for (int t = 0; t < 64; t++) begin
            hi0 += int'(pwm_a[0]);
            hi1 += int'(pwm_a[1]);
            if (pwm_a[0] !== exp_on(t, thr0)) pat0_err++;
            if (pwm_a[1] !== exp_on(t, thr1)) pat1_err++;
            if (wrap_a !== (t == 0)) wrap_err++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_a = 1'b1; wr_a = 1'b0; wsel_a = '0; wdata_a = '0;
        rst_b = 1'b1; wr_b = 1'b0; wsel_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        // write attempted during reset must be ignored
        wr_a = 1'b1; wsel_a = 3'd0; wdata_a = 6'd9;
        @(negedge clk);
        wr_a = 1'b0;
        check("reset_pwm_a", pwm_a, 0);
        check("reset_pend_a", pend_a, 0);
        check("reset_wrap_a", wrap_a, 0);
        check("reset_pwm_b", pwm_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // ch0=16 on both DUTs (b gets 63)
        repeat (5) @(negedge clk);
        wr_a = 1'b1; wsel_a = 3'd0; wdata_a = 6'd16;
        wr_b = 1'b1; wsel_b = 3'd0; wdata_b = 6'd63;
        @(negedge clk);
        wr_a = 1'b0; wr_b = 1'b0;
        check("pend_after_write", pend_a, 2'b01);
        check("pwm_before_apply", pwm_a, 0);
        check("pend_b_after_write", pend_b, 2'b01);
        wait_wrap_a(n);
        check("first_wrap_seen", wrap_a, 1);
        check("first_wrap_delay", n, 58);
        check("pend_clear_at_wrap", pend_a, 0);
        check("pwm_at_tick0", pwm_a, 2'b01);
        measure(16, 0);
        check("ch0_16_highs", hi0, 16);
        check("ch0_16_pattern", pat0_err, 0);
        check("ch1_zero_highs", hi1, 0);
        check("wrap_single_pulse", wrap_err, 0);
        check("wrap_period_64", wrap_a, 1);

        // writes to absent channels 3 and 2 are ignored
        @(negedge clk);
        wr_a = 1'b1; wsel_a = 3'd3; wdata_a = 6'd63;
        @(negedge clk);
        wsel_a = 3'd2;
        @(negedge clk);
        wr_a = 1'b0;
        check("bad_sel_pend", pend_a, 0);
        wait_wrap_a(n);
        check("bad_sel_wrap_delay", n, 61);
        measure(16, 0);
        check("bad_sel_ch0_highs", hi0, 16);
        check("bad_sel_ch1_highs", hi1, 0);
        check("bad_sel_pattern", pat0_err + pat1_err, 0);

        // ch1=10 applied next wrap; ch1=5 written on the wrap tick itself
        wr_a = 1'b1; wsel_a = 3'd1; wdata_a = 6'd10;
        @(negedge clk);
        wr_a = 1'b0;
        check("pend_ch1", pend_a, 2'b10);
        repeat (62) @(negedge clk);
        wr_a = 1'b1; wsel_a = 3'd1; wdata_a = 6'd5;
        @(negedge clk);
        wr_a = 1'b0;
        check("wrap_tick_write_wrap", wrap_a, 1);
        check("write_wins_over_clear", pend_a, 2'b10);
        measure(16, 10);
        check("ch1_old_duty_highs", hi1, 10);
        check("ch1_old_duty_pattern", pat1_err, 0);
        check("pend_clear_second", pend_a, 0);
        measure(16, 5);
        check("ch1_new_duty_highs", hi1, 5);
        check("ch1_new_duty_pattern", pat1_err, 0);

        // ch0=32: alternating with bit reversal, one block otherwise
        wr_a = 1'b1; wsel_a = 3'd0; wdata_a = 6'd32;
        @(negedge clk);
        wr_a = 1'b0;
        wait_wrap_a(n);
        measure(32, 5);
        check("ch0_32_highs", hi0, 32);
        check("ch0_32_pattern", pat0_err, 0);

        // reset mid-period with a pending write
        wr_a = 1'b1; wsel_a = 3'd0; wdata_a = 6'd40;
        @(negedge clk);
        wr_a = 1'b0;
        check("pend_before_reset", pend_a, 2'b01);
        repeat (10) @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("async_reset_pwm", pwm_a, 0);
        check("async_reset_pend", pend_a, 0);
        check("async_reset_wrap", wrap_a, 0);
        @(negedge clk);
        rst_a = 1'b0;
        wait_wrap_a(n);
        check("post_reset_wrap_delay", n, 64);
        check("post_reset_pend", pend_a, 0);
        measure(0, 0);
        check("post_reset_ch0_highs", hi0, 0);
        check("post_reset_ch1_highs", hi1, 0);

        // DUT b: PRESCALE=4, ch0=63
        n = 0;
        while (wrap_b !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("b_wrap_seen", wrap_b, 1);
        check("b_pend_cleared", pend_b, 0);
        hi0 = 0; wrap_err = 0;
        for (int c = 0; c < 256; c++) begin
            hi0 += int'(pwm_b[0]);
            if (wrap_b !== (c == 0)) wrap_err++;
            @(negedge clk);
        end
        check("b_high_cycles", hi0, 252);
        check("b_wrap_single", wrap_err, 0);
        check("b_wrap_spacing_256", wrap_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NCHAN, default 2: number of independent PWM channels (1..8).
REQ-002 Parameter WIDTH, default 6: threshold and counter width in bits (4..10).
REQ-003 Parameter PRESCALE, default 1: CLK cycles per PWM tick (1..256).
REQ-004 CLK  input  1  single clock of the block; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 WR  input  1  single-cycle write strobe, sampled on the CLK rising edge.
REQ-007 WSEL  input  3  channel index for the write.
REQ-008 WDATA  input  WIDTH  new threshold for the selected channel.
REQ-009 PWM  output  NCHAN  registered PWM outputs, one bit per channel.
REQ-010 PEND  output  NCHAN  per-channel flag: shadow threshold written, not yet applied.
REQ-011 WRAP  output  1  one-cycle pulse on the tick where the counter wraps.

Function
REQ-012 Prescaler counts 0..PRESCALE-1 and asserts an internal tick on the cycle its value is PRESCALE-1; with PRESCALE=1 every cycle is a tick.
REQ-013 Period counter is WIDTH bits, increments by 1 on each tick, wraps from 2^WIDTH-1 to 0; a period is 2^WIDTH ticks.
REQ-014 Each channel holds a shadow threshold and an active threshold, both WIDTH bits.
REQ-015 WR with WSEL < NCHAN writes WDATA into that channel's shadow and sets its PEND bit on the next edge; WR with WSEL >= NCHAN is ignored with no state change.
REQ-016 On the tick where the counter is 2^WIDTH-1, every channel with PEND set copies shadow to active, and PEND clears.
REQ-017 A write on that same wrap-tick cycle updates the shadow and leaves PEND set; the new value is applied at the following wrap (write wins over clear).
REQ-018 On each tick, PWM[i] is registered as (compare value < active[i]), where the compare value is the counter value after the tick's increment; PWM holds its value between ticks.
REQ-019 Threshold 0 gives PWM constantly low; threshold T gives exactly T high ticks per period; the maximum threshold gives 2^WIDTH-1 high ticks.
REQ-020 WRAP is high for exactly one CLK cycle, on the cycle after the wrap tick, and is aligned with the edge where active thresholds change.
REQ-021 Latency from WR to a visible PWM change is at most one full period plus one tick.
REQ-022 Active thresholds are never partially updated; all pending channels switch on the same edge.

Reset
REQ-023 RST high asynchronously clears the prescaler, counter, all shadow and active thresholds, PEND, PWM and WRAP to zero.
REQ-024 RST asserted mid-period discards pending writes; after release, the first tick increments the counter from 0.
REQ-025 WR is ignored while RST is high.

Configuration
REQ-026 Macro PWM_BITREV_EN defined: the compare value is the bit-reversed period counter (bit 0 becomes MSB), which spreads high ticks across the period and pushes ripple to higher frequencies.
REQ-027 Macro PWM_BITREV_EN undefined: the compare value is the plain counter, giving a single contiguous high pulse at the start of each period.
REQ-028 High-tick count per period for a given threshold is identical in both configurations.

Verification
REQ-029 NCHAN=2, WIDTH=6, PRESCALE=1, no BITREV: write ch0=16 -> after the next WRAP, PWM[0] is high for ticks 0..15 and low for 16..63; PEND[0] clears at WRAP.
REQ-030 Same setup with PWM_BITREV_EN, ch0=32 -> PWM[0] alternates high/low every tick; 32 high ticks per period.
REQ-031 Write ch1=5 on the exact wrap-tick cycle -> PEND[1] stays 1; PWM[1] stays at the old duty for one more period, then shows 5 high ticks.
REQ-032 Write with WSEL=3 and value 63 while NCHAN=2 -> PEND, shadows and PWM are unchanged.
REQ-033 PRESCALE=4, ch0=63 -> period of 256 CLK cycles, PWM[0] high for 252 cycles, WRAP spacing 256 cycles.
REQ-034 Pulse RST mid-period with PEND[0]=1 -> all outputs 0 immediately; no update is applied at the next WRAP.
